// File: rtl/xc_aesmix_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xc_aesmix_seq
// Purpose  : Runs a 128-bit (Inv)MixColumns through the shared xc_aesmix
//            datapath, one 32-bit column at a time.
// Revision : 1.0 - initial release
// ============================================================================
module xc_aesmix_seq #(
  parameter int NCOLS = 4  // only 4 is supported
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_enc,
  input  logic [32*NCOLS-1:0]  req_state,
  input  logic                 abort,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [32*NCOLS-1:0]  rsp_state,
  output logic                 busy,
  output logic                 mix_flush,
  output logic [31:0]          mix_flush_data,
  output logic                 mix_valid,
  output logic [31:0]          mix_rs1,
  output logic [31:0]          mix_rs2,
  output logic                 mix_enc,
  input  logic                 mix_ready,
  input  logic [31:0]          mix_result
);

  localparam int COL_W = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [32*NCOLS-1:0]  op_q, op_d;
  logic                 enc_q, enc_d;
  logic [32*NCOLS-1:0]  res_q, res_d;

  logic [COL_W+4:0]     w_base;
  logic [31:0]          w_cur_col;

  assign w_base    = {col_q, 5'b0};
  assign w_cur_col = op_q[w_base +: 32];

  // abort wins over accept, column writeback and response handshake alike
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    op_d    = op_q;
    enc_d   = enc_q;
    res_d   = res_q;
    if (abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_d    = req_state;
            enc_d   = req_enc;
            col_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (mix_ready) begin
            res_d[w_base +: 32] = mix_result;
            if (col_q == COL_W'(NCOLS - 1)) begin
              state_d = ST_DONE;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      op_q    <= '0;
      enc_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      op_q    <= op_d;
      enc_q   <= enc_d;
      res_q   <= res_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign rsp_valid      = (state_q == ST_DONE);
  assign rsp_state      = res_q;
  assign mix_valid      = (state_q == ST_RUN);
  // the datapath sees a flush on every new request and on every cancel
  assign mix_flush      = abort | ((state_q == ST_IDLE) & req_valid);
  assign mix_flush_data = 32'h0;
  assign mix_rs1        = {16'h0, w_cur_col[15:0]};
  assign mix_rs2        = {w_cur_col[31:16], 16'h0};
  assign mix_enc        = enc_q;

endmodule
`default_nettype wire

// File: tb/tb_xc_aesmix_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xc_aesmix_seq
// Purpose  : Self-checking bench for xc_aesmix_seq with a datapath emulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xc_aesmix_seq;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_enc = 1'b0;
  logic [127:0] req_state = '0;
  logic         abort = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [127:0] rsp_state;
  logic         busy;
  logic         mix_flush;
  logic [31:0]  mix_flush_data;
  logic         mix_valid;
  logic [31:0]  mix_rs1;
  logic [31:0]  mix_rs2;
  logic         mix_enc;
  logic         mix_ready = 1'b0;
  logic [31:0]  mix_result = '0;

  int n_vec = 0;
  int n_err = 0;
  int wait_cyc = 0;
  bit junk_en = 1'b0;

  xc_aesmix_seq #(.NCOLS(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_enc(req_enc), .req_state(req_state),
    .abort(abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state),
    .busy(busy),
    .mix_flush(mix_flush), .mix_flush_data(mix_flush_data),
    .mix_valid(mix_valid), .mix_rs1(mix_rs1), .mix_rs2(mix_rs2), .mix_enc(mix_enc),
    .mix_ready(mix_ready), .mix_result(mix_result)
  );

  always #5 clock = ~clock;

  // ---------------- AES arithmetic reference ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] col, input logic enc);
    logic [7:0] a [4];
    logic [7:0] m [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = col[8*i +: 8];
    if (enc) begin
      m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1;
    end else begin
      m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9;
    end
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = gmul(m[0], a[i]) ^ gmul(m[1], a[(i+1)%4]) ^
                    gmul(m[2], a[(i+2)%4]) ^ gmul(m[3], a[(i+3)%4]);
    return r;
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic enc);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = mixcol(s[32*c +: 32], enc);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- datapath emulator ----------------
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (mix_valid) begin
        if (cnt >= wait_cyc) begin
          mix_ready  = 1'b1;
          mix_result = mixcol({mix_rs2[31:16], mix_rs1[15:0]}, mix_enc);
          cnt = 0;
        end else begin
          mix_ready = 1'b0;
          cnt++;
        end
      end else begin
        cnt = 0;
        mix_ready  = junk_en && ($urandom_range(0, 3) == 0);
        mix_result = $urandom;
      end
    end
  end

  // ---------------- behavioural model ----------------
  bit           m_active;
  int           m_cols;
  logic [127:0] m_in;
  logic         m_enc;
  logic [127:0] m_res;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_cols   <= 0;
      m_in     <= '0;
      m_enc    <= 1'b0;
      m_res    <= '0;
    end else if (abort) begin
      m_active <= 1'b0;
      m_cols   <= 0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active <= 1'b1;
        m_cols   <= 0;
        m_in     <= req_state;
        m_enc    <= req_enc;
      end
    end else if (m_cols < 4) begin
      if (mix_ready) begin
        m_res[32*m_cols +: 32] <= mix_result;
        m_cols <= m_cols + 1;
      end
    end else if (rsp_ready) begin
      m_active <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset) begin
      chk("req_ready", 128'(req_ready), 128'(!m_active));
      chk("busy", 128'(busy), 128'(m_active));
      chk("rsp_valid", 128'(rsp_valid), 128'(m_active && m_cols == 4));
      chk("mix_valid", 128'(mix_valid), 128'(m_active && m_cols < 4));
      chk("mix_flush", 128'(mix_flush), 128'(abort || (!m_active && req_valid)));
      chk("mix_flush_data", 128'(mix_flush_data), 128'(0));
      chk("rsp_state_hold", rsp_state, m_res);
      if (m_active && m_cols < 4) begin
        chk("mix_rs1", 128'(mix_rs1), 128'({16'h0, m_in[32*m_cols +: 16]}));
        chk("mix_rs2", 128'(mix_rs2), 128'({m_in[32*m_cols+16 +: 16], 16'h0}));
        chk("mix_enc", 128'(mix_enc), 128'(m_enc));
      end
      if (m_active && m_cols == 4)
        chk("rsp_state_mix", rsp_state, mix_state(m_in, m_enc));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic enc, input logic [127:0] st);
    int k;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (!req_ready) chk("idle_timeout", 128'(req_ready), 128'(1));
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_enc   = enc;
    req_state = st;
    @(negedge clock);
    chk("accept_flush", 128'(mix_flush), 128'(1));
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) chk("rsp_timeout", 128'(rsp_valid), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [127:0] st;
    logic [127:0] snap;
    logic         enc;
    bit           done;

    chk("pin_model_enc", mix_state({4{32'h455313db}}, 1'b1), {4{32'hbca14d8e}});
    chk("pin_model_dec", mix_state({32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6}, 1'b0),
        {32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6});

    repeat (3) @(posedge clock);
    #2;
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_req_ready", 128'(req_ready), 128'(1));
    chk("reset_rsp_state", rsp_state, 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // encrypt, fast datapath
    wait_cyc = 0;
    send(1'b1, {4{32'h455313db}});
    wait_rsp(lat);
    chk("enc_latency", 128'(lat), 128'(5));
    chk("enc_result", rsp_state, {4{32'hbca14d8e}});

    // decrypt follows at the minimum accept interval
    send(1'b0, {32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6});
    wait_rsp(lat);
    chk("dec_latency", 128'(lat), 128'(5));
    chk("dec_result", rsp_state, {32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6});

    // slow datapath
    wait_cyc = 3;
    send(1'b1, {4{32'h455313db}});
    wait_rsp(lat);
    chk("slow_latency", 128'(lat), 128'(17));
    chk("slow_result", rsp_state, {4{32'hbca14d8e}});
    wait_cyc = 0;

    // response backpressure
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    st = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, st);
    wait_rsp(lat);
    snap = rsp_state;
    chk("bp_result", snap, mix_state(st, 1'b1));
    repeat (10) begin
      @(negedge clock);
      chk("bp_valid", 128'(rsp_valid), 128'(1));
      chk("bp_state", rsp_state, snap);
      chk("bp_req_ready", 128'(req_ready), 128'(0));
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_release_idle", 128'(req_ready), 128'(1));
    chk("bp_state_kept", rsp_state, snap);

    // abort during column 2
    send(1'b1, {$urandom, $urandom, $urandom, $urandom});
    @(posedge clock); #1;
    @(posedge clock); #1;
    abort = 1'b1;
    @(negedge clock);
    chk("abort_flush", 128'(mix_flush), 128'(1));
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    chk("abort_idle", 128'(req_ready), 128'(1));
    repeat (3) begin
      @(negedge clock);
      chk("abort_no_rsp", 128'(rsp_valid), 128'(0));
    end
    send(1'b1, {4{32'h5c220af2}});
    wait_rsp(lat);
    chk("post_abort_latency", 128'(lat), 128'(5));
    chk("post_abort_result", rsp_state, {4{32'h9d58dc9f}});

    // abort in IDLE blocks a simultaneous request
    @(posedge clock); #1;
    abort = 1'b1;
    req_valid = 1'b1;
    @(negedge clock);
    chk("idle_abort_flush", 128'(mix_flush), 128'(1));
    @(posedge clock); #1;
    abort = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    chk("idle_abort_not_busy", 128'(busy), 128'(0));

    // asynchronous reset while holding a response
    rsp_ready = 1'b0;
    send(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_rsp(lat);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("areset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("areset_req_ready", 128'(req_ready), 128'(1));
    chk("areset_rsp_state", rsp_state, 128'(0));
    #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    st = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, st);
    wait_rsp(lat);
    chk("areset_after_latency", 128'(lat), 128'(5));
    chk("areset_after_result", rsp_state, mix_state(st, 1'b0));

    // randomized traffic
    junk_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      wait_cyc = $urandom_range(0, 3);
      enc = 1'($urandom_range(0, 1));
      send(enc, {$urandom, $urandom, $urandom, $urandom});
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        abort     = (t % 2 == 1) && ($urandom_range(0, 23) == 0);
        rsp_ready = 1'($urandom_range(0, 1));
        req_valid = ($urandom_range(0, 3) == 0);
        @(negedge clock);
        if (abort || (rsp_valid && rsp_ready)) done = 1'b1;
        @(posedge clock); #1;
      end
      if (!done) chk("rand_timeout", 128'(done), 128'(1));
      abort = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    junk_en = 1'b0;
    repeat (4) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
